// File: rtl/bin2qdi_pkg.sv
// rtl/bin2qdi_pkg.sv - shared types and helpers for the binary-to-QDI bus bridge
//
// Contents:
//   state_e   : handshake FSM states (S_WAITEN, S_IDLE, S_DATA)
//   enc_1of4  : 2-bit binary value to one-hot 1-of-4 rail pattern

package bin2qdi_pkg;

  typedef enum logic [1:0] {
    S_WAITEN = 2'd0,  // rails neutral, waiting for the receiver to re-enable
    S_IDLE   = 2'd1,  // rails neutral, receiver ready, waiting for data
    S_DATA   = 2'd2   // rails carry a valid codeword, waiting for acknowledge
  } state_e;

  // 00 -> 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000
  function automatic logic [3:0] enc_1of4(input logic [1:0] b);
    logic [3:0] r;
    r = '0;
    r[b] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/qdi_sync.sv
// rtl/qdi_sync.sv - multi-flop synchroniser for a single asynchronous level
//
// Ports:
//   clk_i  : sampling clock
//   rst_ni : asynchronous active-low reset, clears every stage to 0
//   d_i    : asynchronous input level
//   q_o    : synchronised level, STAGES clock edges behind d_i

module qdi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/bin2qdi_bus.sv
// rtl/bin2qdi_bus.sv - clocked binary producer to four-phase e1of4 QDI channel bridge
//
// Ports:
//   CLK       : single clock, all state on rising edge
//   RESETn    : asynchronous active-low reset
//   din       : binary word, 2*DIGITS bits
//   din_valid : producer offers din
//   din_ready : FIFO not full; word moves when din_valid && din_ready
//   R         : e1of4 rails, digit k on R[4k+3:4k], register-driven
//   Re        : right enable from the QDI receiver, asynchronous to CLK
//   err       : sticky flag, receiver acknowledged while no data was offered
//   tok_cnt   : completed four-phase tokens, wraps silently

module bin2qdi_bus
  import bin2qdi_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [2*DIGITS-1:0]   din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [4*DIGITS-1:0]   R,
  input  logic                  Re,
  output logic                  err,
  output logic [CNT_W-1:0]      tok_cnt
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  // ---------------------------------------------------------------
  // Re synchroniser
  // ---------------------------------------------------------------
  logic re_s;

  qdi_sync #(
    .STAGES (SYNC_STAGES)
  ) u_re_sync (
    .clk_i  (CLK),
    .rst_ni (RESETn),
    .d_i    (Re),
    .q_o    (re_s)
  );

  // ---------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------
  logic [2*DIGITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;
  logic                ready_q, ready_d;
  logic                push, pop, empty;

  assign push  = din_valid && ready_q;
  assign empty = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // Ready is registered from the post-edge occupancy so it never has a
  // combinational path from the FSM's pop decision.
  assign ready_d = (count_d != FULL_CNT);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // ---------------------------------------------------------------
  // Head-of-FIFO encoding
  // ---------------------------------------------------------------
  logic [2*DIGITS-1:0] head;
  logic [4*DIGITS-1:0] head_enc;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    head_enc = '0;
    for (int k = 0; k < DIGITS; k++) begin
      head_enc[4*k +: 4] = enc_1of4(head[2*k +: 2]);
    end
  end

  // ---------------------------------------------------------------
  // Four-phase handshake FSM
  // ---------------------------------------------------------------
  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] r_q, r_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    tok_q, tok_d;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    err_d   = err_q;
    tok_d   = tok_q;
    pop     = 1'b0;
    unique case (state_q)
      S_WAITEN: begin
        r_d = '0;
        if (re_s) state_d = S_IDLE;
      end
      S_IDLE: begin
        r_d = '0;
        // An acknowledge with neutral rails is a protocol violation; it
        // wins over a pop so no word is lost into a broken handshake.
        if (!re_s) begin
          err_d   = 1'b1;
          state_d = S_WAITEN;
        end else if (!empty) begin
          pop     = 1'b1;
          r_d     = head_enc;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!re_s) begin
          r_d     = '0;
          tok_d   = tok_q + CNT_W'(1);
          state_d = S_WAITEN;
        end
      end
      default: begin
        r_d     = '0;
        state_d = S_WAITEN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_WAITEN;
      r_q     <= '0;
      err_q   <= 1'b0;
      tok_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      err_q   <= err_d;
      tok_q   <= tok_d;
    end
  end

  assign din_ready = ready_q;
  assign R         = r_q;
  assign err       = err_q;
  assign tok_cnt   = tok_q;

endmodule

// File: tb/tb_bin2qdi_bus.sv
// tb/tb_bin2qdi_bus.sv - directed self-checking bench for bin2qdi_bus

module tb_bin2qdi_bus;

  logic       CLK;
  logic       RESETn;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] R;
  logic       Re;
  logic       err;
  logic [3:0] tok_cnt;

  int n_total;
  int n_bad;

  logic [3:0] vw [16];
  logic [7:0] ve [16];

  bin2qdi_bus #(
    .DIGITS      (2),
    .DEPTH       (4),
    .SYNC_STAGES (2),
    .CNT_W       (4)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .R         (R),
    .Re        (Re),
    .err       (err),
    .tok_cnt   (tok_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] w, input string tag);
    logic took;
    took      = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 30 && !took; i++) begin
      took = din_ready;
      tick(1);
    end
    din_valid = 1'b0;
    chk({tag, "_accept"}, 32'(took), 32'd1);
  endtask

  // Offer consecutive words each cycle for a fixed window, counting accepts.
  task automatic fill(input int base, input int cycles, output int acc);
    logic took;
    acc       = 0;
    din_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      din  = vw[base + acc];
      took = din_ready;
      tick(1);
      if (took) acc++;
    end
    din_valid = 1'b0;
  endtask

  // Receiver side of one four-phase token.
  task automatic token(input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    while (R == 8'h00 && n < 20) begin
      tick(1);
      n++;
    end
    chk({tag, "_R"}, 32'(R), 32'(exp));
    Re = 1'b0;
    n  = 0;
    while (R != 8'h00 && n < 20) begin
      tick(1);
      n++;
    end
    chk({tag, "_clr"}, 32'(R), 32'h0);
    Re = 1'b1;
    tick(3);
  endtask

  initial begin
    int acc;
    int n;

    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 16; i++) begin
      vw[i] = 4'h0;
      ve[i] = 8'h00;
    end
    vw[0] = 4'h0; ve[0] = 8'h11;
    vw[1] = 4'h5; ve[1] = 8'h22;
    vw[2] = 4'hA; ve[2] = 8'h44;
    vw[3] = 4'hF; ve[3] = 8'h88;
    vw[4] = 4'h3; ve[4] = 8'h18;
    vw[5] = 4'hC; ve[5] = 8'h81;
    vw[6] = 4'h6; ve[6] = 8'h24;
    vw[7] = 4'hE; ve[7] = 8'h84;
    vw[8] = 4'h1; ve[8] = 8'h12;
    vw[9] = 4'h9; ve[9] = 8'h42;

    RESETn    = 1'b0;
    din       = 4'h0;
    din_valid = 1'b0;
    Re        = 1'b1;

    // Reset state
    tick(2);
    chk("rst_R",       32'(R),         32'h0);
    chk("rst_ready",   32'(din_ready), 32'h0);
    chk("rst_err",     32'(err),       32'h0);
    chk("rst_tok",     32'(tok_cnt),   32'h0);

    // Basic token with exact latency
    RESETn = 1'b1;
    tick(1);
    chk("rel_ready_first_edge", 32'(din_ready), 32'h1);
    chk("rel_R", 32'(R), 32'h0);
    tick(2);
    push(4'h9, "t1_push");
    chk("t1_R_before_pop", 32'(R), 32'h0);
    tick(1);
    chk("t1_latency", 32'(R), 32'h42);
    Re = 1'b0;
    tick(2);
    chk("t1_hold_during_sync", 32'(R), 32'h42);
    tick(1);
    chk("t1_R_cleared", 32'(R), 32'h0);
    chk("t1_tok", 32'(tok_cnt), 32'h1);
    Re = 1'b1;
    tick(3);
    chk("t1_err", 32'(err), 32'h0);

    // Back-pressure and ordering
    push(vw[0], "t2_push0");
    tick(1);
    chk("t2_R0", 32'(R), 32'(ve[0]));
    fill(1, 6, acc);
    chk("t2_accepted", 32'(acc), 32'd4);
    chk("t2_ready_low", 32'(din_ready), 32'h0);
    chk("t2_R0_held", 32'(R), 32'(ve[0]));
    token(ve[0], "t2_tok0");
    push(vw[5], "t2_push5");
    for (int i = 1; i <= 5; i++) begin
      token(ve[i], $sformatf("t2_tok%0d", i));
    end
    chk("t2_tok", 32'(tok_cnt), 32'h7);

    // Acknowledge without data
    Re = 1'b0;
    tick(2);
    chk("t3_err_not_yet", 32'(err), 32'h0);
    tick(1);
    chk("t3_err_set", 32'(err), 32'h1);
    chk("t3_R_zero", 32'(R), 32'h0);
    Re = 1'b1;
    tick(3);
    chk("t3_err_sticky", 32'(err), 32'h1);
    push(vw[6], "t3_push");
    token(ve[6], "t3_tok");
    chk("t3_tok_cnt", 32'(tok_cnt), 32'h8);
    chk("t3_err_still", 32'(err), 32'h1);

    // Reset in the middle of a token with words queued
    push(vw[7], "t4_push7");
    tick(1);
    push(vw[8], "t4_push8");
    push(vw[9], "t4_push9");
    push(vw[0], "t4_push0");
    chk("t4_R_before_rst", 32'(R), 32'(ve[7]));
    RESETn = 1'b0;
    #1;
    chk("t4_rst_R",     32'(R),         32'h0);
    chk("t4_rst_tok",   32'(tok_cnt),   32'h0);
    chk("t4_rst_err",   32'(err),       32'h0);
    chk("t4_rst_ready", 32'(din_ready), 32'h0);
    tick(1);
    RESETn = 1'b1;
    tick(1);
    chk("t4_ready_after", 32'(din_ready), 32'h1);
    tick(2);
    push(vw[1], "t4_push_new");
    token(ve[1], "t4_fifo_was_empty");
    chk("t4_tok", 32'(tok_cnt), 32'h1);

    // Counter wrap and simultaneous push/pop at occupancy 2
    RESETn = 1'b0;
    tick(1);
    RESETn = 1'b1;
    tick(3);
    push(vw[2], "t5_pushA");
    tick(1);
    chk("t5_RA", 32'(R), 32'(ve[2]));
    push(vw[3], "t5_pushB");
    push(vw[4], "t5_pushC");
    Re = 1'b0;
    n  = 0;
    while (R != 8'h00 && n < 20) begin
      tick(1);
      n++;
    end
    chk("t5_A_ack", 32'(R), 32'h0);
    Re = 1'b1;
    tick(3);
    din       = vw[5];
    din_valid = 1'b1;
    chk("t5_ready_occ2", 32'(din_ready), 32'h1);
    tick(1);
    din_valid = 1'b0;
    chk("t5_pop_with_push", 32'(R), 32'(ve[3]));
    fill(6, 4, acc);
    chk("t5_occ_kept_2", 32'(acc), 32'd2);
    chk("t5_ready_low", 32'(din_ready), 32'h0);
    for (int i = 3; i <= 7; i++) begin
      token(ve[i], $sformatf("t5_tok%0d", i));
    end
    chk("t5_tok6", 32'(tok_cnt), 32'h6);
    for (int i = 0; i < 10; i++) begin
      push(vw[i], $sformatf("t5_lpush%0d", i));
      token(ve[i], $sformatf("t5_ltok%0d", i));
    end
    chk("t5_tok_wrap0", 32'(tok_cnt), 32'h0);
    push(vw[8], "t5_push17");
    token(ve[8], "t5_tok17");
    chk("t5_tok17", 32'(tok_cnt), 32'h1);
    chk("t5_err", 32'(err), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bin2qdi_bus.md
BIN2QDI_BUS -- requirements
Module: bin2qdi_bus

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2: number of e1of4 output digits; binary data width is 2*DIGITS.
REQ-002 The block SHALL have parameter DEPTH, default 4: input FIFO depth in words; power of two and at least 2.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: flops in the Re synchroniser; at least 2.
REQ-004 The block SHALL have parameter CNT_W, default 16: width of the completed-token counter.
REQ-005 CLK  in  1  single clock; all state on rising edge.
REQ-006 RESETn  in  1  reset, asynchronous and active-low.
REQ-007 din  in  2*DIGITS  binary word from the Verilog-side producer.
REQ-008 din_valid  in  1  producer offers din.
REQ-009 din_ready  out  1  FIFO can accept; a word transfers on a cycle with din_valid and din_ready both high.
REQ-010 R  out  4*DIGITS  e1of4 data rails to the QDI circuit; digit k occupies R[4k+3:4k].
REQ-011 Re  in  1  right enable from the QDI circuit; asynchronous to CLK.
REQ-012 err  out  1  sticky protocol-error flag.
REQ-013 tok_cnt  out  CNT_W  count of completed four-phase tokens.

Function
REQ-014 Encoding SHALL map digit k bits din[2k+1:2k] as 00->0001, 01->0010, 10->0100, 11->1000 on R[4k+3:4k].
REQ-015 din_ready SHALL equal not-full and SHALL NOT depend on a same-cycle pop; a write at full never occurs.
REQ-016 The FIFO SHALL be first-in-first-out with wrapping pointers and an occupancy counter of width log2(DEPTH)+1.
REQ-017 Re SHALL pass through SYNC_STAGES flops, all reset to 0, giving Re_s; only Re_s is used by the FSM.
REQ-018 FSM state S_WAITEN: R all zero; Re_s==1 -> S_IDLE.
REQ-019 FSM state S_IDLE: R all zero; on FIFO non-empty, pop the head, register its encoding onto R and go to S_DATA.
REQ-020 In S_IDLE with Re_s==0, the block SHALL set err and go to S_WAITEN (acknowledge without data); this takes priority over a pop.
REQ-021 FSM state S_DATA: R holds the encoded word unchanged; Re_s==0 -> R cleared to zero at the same edge, tok_cnt incremented, go to S_WAITEN.
REQ-022 R SHALL be driven only from registers, with exactly one rail high per digit in S_DATA and all rails low otherwise; no glitches.
REQ-023 Latency: a word written at edge t into an empty FIFO with the FSM in S_IDLE SHALL appear on R at edge t+1.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged and SHALL preserve order.
REQ-025 tok_cnt SHALL wrap from 2^CNT_W-1 to 0 without flagging.
REQ-026 err SHALL remain set until reset; the block SHALL continue operating after err is set.

Reset
REQ-027 While RESETn==0, the block SHALL hold R=0, din_ready=0, err=0, tok_cnt=0, FIFO empty, synchroniser flops=0, and state S_WAITEN, all asynchronously.
REQ-028 After RESETn rises, din_ready SHALL go to 1 on the first clock edge; a token in flight at reset is discarded and is not counted.

Structure
REQ-029 Shared package bin2qdi_pkg SHALL hold the FSM state enum (S_WAITEN, S_IDLE, S_DATA) and the 2-bit-to-1of4 encode function.
REQ-030 The synchroniser SHALL be sub-module qdi_sync (parameter STAGES, async active-low reset to 0); the FIFO and FSM SHALL be inline.

Verification (DIGITS=2, DEPTH=4, SYNC_STAGES=2)
REQ-031 Reset, Re=1, push din=4'b1001 -> R=8'b0100_0010 one edge after the FSM reaches S_IDLE; Re low -> R=0 within 3 edges, tok_cnt=1.
REQ-032 Hold Re=1, push 5 words back-to-back -> din_ready low after 4 accepted words; words emerge in order, one per Re cycle.
REQ-033 Drop Re in S_IDLE with the FIFO empty -> err=1 sticky, R stays 0, the next token still completes.
REQ-034 Assert RESETn=0 mid-S_DATA with 3 words queued -> R=0 immediately, FIFO empty, tok_cnt=0.
REQ-035 CNT_W=4, run 17 tokens -> tok_cnt=1, err=0; simultaneous push and pop at occupancy 2 keeps occupancy at 2.
